flow_key_lookup_ctrl: RTL and testbench
=======================================

FLOW_KEY_LOOKUP_CTRL -- requirements
Module: flow_key_lookup_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 64, max cycles to wait for a TCAM response (range 2..65535).
REQ-002 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port key_valid  input  1  metadata-stage holds a valid parsed key.
REQ-005 SHALL have port key_ready  output  1  block accepts key this cycle.
REQ-006 SHALL have ports key_src_ip/key_dst_ip  input  32 each; key_ip_proto  input  8; key_src_port/key_dst_port  input  16 each; key_vlan_id  input  12; key_dscp  input  6; key_is_ipv4, key_is_ipv6, key_is_arp, key_is_fragmented  input  1 each.
REQ-007 SHALL have ports tcam_req_valid  output  1; tcam_req_ready  input  1; tcam_key  output  128  packed lookup key.
REQ-008 SHALL have ports tcam_rsp_valid  input  1; tcam_rsp_hit  input  1; tcam_rsp_index  input  8.
REQ-009 SHALL have ports res_valid  output  1; res_ready  input  1; res_hit  output  1; res_index  output  8; res_timeout  output  1.
REQ-010 SHALL have ports stat_lookups, stat_misses, stat_timeouts  output  16 each.

Function
REQ-011 SHALL implement FSM IDLE, REQ, WAIT, OUT; key_ready = (state==IDLE), registered-state decode only.
REQ-012 IDLE: key_valid=1 -> register normalized key, go REQ; no capture otherwise.
REQ-013 REQ: tcam_req_valid=1, tcam_key stable from register; tcam_req_ready=1 -> clear timer, increment stat_lookups, go WAIT.
REQ-014 WAIT: tcam_rsp_valid=1 -> register hit/index, res_timeout=0, go OUT; else timer+1; timer==TIMEOUT_CYC-1 without response -> res_hit=0, res_index=0, res_timeout=1, go OUT.
REQ-015 Response and timeout in same cycle SHALL be treated as response.
REQ-016 OUT: res_valid=1, result fields stable; res_ready=1 -> go IDLE.
REQ-017 tcam_rsp_valid outside WAIT SHALL be ignored, no state/stat change.
REQ-018 Key layout: [127:96] src_ip, [95:64] dst_ip, [63:56] proto, [55:40] src_port, [39:24] dst_port, [23:12] vlan_id, [11:6] dscp, [5] ipv4, [4] ipv6, [3] arp, [2] fragmented, [1:0] 2'b00.
REQ-019 Normalization: is_arp=1 -> proto, src_port, dst_port forced 0; is_fragmented=1 -> ports forced 0; neither ipv4 nor ipv6 nor arp -> src_ip, dst_ip, proto, ports forced 0.
REQ-020 stat_misses +1 on response with hit=0; stat_timeouts +1 on timeout; all stats saturate at 16'hFFFF.
REQ-021 Min latency: key accepted edge N, tcam_req_valid high cycle N+1; response at N+2 -> res_valid at N+3.
REQ-022 Backpressure on tcam_req_ready or res_ready SHALL hold state and outputs indefinitely.

Reset
REQ-023 rst_n low SHALL asynchronously force state IDLE, tcam_req_valid=0, res_valid=0, res_hit=0, res_index=0, res_timeout=0, tcam_key=0, timer=0, all stats=0.
REQ-024 Reset mid-transaction SHALL drop in-flight lookup; a later response is ignored per REQ-017.

Structure
REQ-025 Shared package net_dp_pkg SHALL hold key width (128), field offsets, FSM state encoding.
REQ-026 Combinational normalize/pack logic SHALL be one sub-module flow_key_pack; FSM, timer, stats in top.

Verification
REQ-027 IPv4 TCP key (10.0.0.1->10.0.0.2, proto 6, ports 1234/80, vlan 5, dscp 46), tcam_req_ready=1, hit idx 0x17 after 1 cycle -> tcam_key matches REQ-018, res_valid at N+3, res_hit=1, res_index=0x17, stat_lookups=1.
REQ-028 ARP key with nonzero ports/proto -> tcam_key[63:24]=0, bit3=1.
REQ-029 No response, TIMEOUT_CYC=4 -> res_timeout=1, res_hit=0 after 4 WAIT cycles; stat_timeouts=1.
REQ-030 Response arriving on timeout cycle -> res_timeout=0, hit reported.
REQ-031 res_ready held 0 for 10 cycles with key_valid=1 -> key_ready=0 throughout, result stable, no second lookup.
REQ-032 rst_n asserted during WAIT, stray response after release -> all outputs 0, state IDLE, stats 0, no res_valid.

Source files
------------

// File: rtl/net_dp_pkg.sv
// Shared datapath definitions for the flow lookup path: key width, key field
// offsets, lookup FSM encoding and a saturating counter helper.
package net_dp_pkg;

  localparam int KEY_W        = 128;
  localparam int SRC_IP_LSB   = 96;
  localparam int DST_IP_LSB   = 64;
  localparam int PROTO_LSB    = 56;
  localparam int SRC_PORT_LSB = 40;
  localparam int DST_PORT_LSB = 24;
  localparam int VLAN_LSB     = 12;
  localparam int DSCP_LSB     = 6;
  localparam int IPV4_BIT     = 5;
  localparam int IPV6_BIT     = 4;
  localparam int ARP_BIT      = 3;
  localparam int FRAG_BIT     = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_OUT  = 2'd3
  } lookup_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/flow_key_lookup_ctrl_if.sv
// Key, TCAM and result handshake bundle of the flow key lookup controller.
// slave is the controller side, master is the surrounding pipeline/TCAM side.
interface flow_key_lookup_ctrl_if;
  import net_dp_pkg::*;

  logic              key_valid;
  logic              key_ready;
  logic [31:0]       key_src_ip;
  logic [31:0]       key_dst_ip;
  logic [7:0]        key_ip_proto;
  logic [15:0]       key_src_port;
  logic [15:0]       key_dst_port;
  logic [11:0]       key_vlan_id;
  logic [5:0]        key_dscp;
  logic              key_is_ipv4;
  logic              key_is_ipv6;
  logic              key_is_arp;
  logic              key_is_fragmented;

  logic              tcam_req_valid;
  logic              tcam_req_ready;
  logic [KEY_W-1:0]  tcam_key;
  logic              tcam_rsp_valid;
  logic              tcam_rsp_hit;
  logic [7:0]        tcam_rsp_index;

  logic              res_valid;
  logic              res_ready;
  logic              res_hit;
  logic [7:0]        res_index;
  logic              res_timeout;

  modport slave (
    input  key_valid, key_src_ip, key_dst_ip, key_ip_proto, key_src_port,
           key_dst_port, key_vlan_id, key_dscp, key_is_ipv4, key_is_ipv6,
           key_is_arp, key_is_fragmented,
           tcam_req_ready, tcam_rsp_valid, tcam_rsp_hit, tcam_rsp_index,
           res_ready,
    output key_ready, tcam_req_valid, tcam_key,
           res_valid, res_hit, res_index, res_timeout
  );

  modport master (
    output key_valid, key_src_ip, key_dst_ip, key_ip_proto, key_src_port,
           key_dst_port, key_vlan_id, key_dscp, key_is_ipv4, key_is_ipv6,
           key_is_arp, key_is_fragmented,
           tcam_req_ready, tcam_rsp_valid, tcam_rsp_hit, tcam_rsp_index,
           res_ready,
    input  key_ready, tcam_req_valid, tcam_key,
           res_valid, res_hit, res_index, res_timeout
  );

endinterface

// File: rtl/flow_key_pack.sv
// Normalizes parsed header fields and packs them into the 128-bit TCAM key.
// Fields that are meaningless for the packet class are zeroed so they never match.
module flow_key_pack
  import net_dp_pkg::*;
(
  input  logic [31:0]      src_ip,
  input  logic [31:0]      dst_ip,
  input  logic [7:0]       ip_proto,
  input  logic [15:0]      src_port,
  input  logic [15:0]      dst_port,
  input  logic [11:0]      vlan_id,
  input  logic [5:0]       dscp,
  input  logic             is_ipv4,
  input  logic             is_ipv6,
  input  logic             is_arp,
  input  logic             is_fragmented,
  output logic [KEY_W-1:0] key
);

  logic known_l3;
  logic keep_ips;
  logic keep_proto;
  logic keep_ports;

  assign known_l3   = is_ipv4 | is_ipv6 | is_arp;
  assign keep_ips   = known_l3;
  assign keep_proto = known_l3 & ~is_arp;
  // Fragments after the first carry no L4 header, so ports are not trusted.
  assign keep_ports = known_l3 & ~is_arp & ~is_fragmented;

  always_comb begin
    key = '0;
    key[SRC_IP_LSB   +: 32] = keep_ips   ? src_ip   : 32'd0;
    key[DST_IP_LSB   +: 32] = keep_ips   ? dst_ip   : 32'd0;
    key[PROTO_LSB    +: 8]  = keep_proto ? ip_proto : 8'd0;
    key[SRC_PORT_LSB +: 16] = keep_ports ? src_port : 16'd0;
    key[DST_PORT_LSB +: 16] = keep_ports ? dst_port : 16'd0;
    key[VLAN_LSB     +: 12] = vlan_id;
    key[DSCP_LSB     +: 6]  = dscp;
    key[IPV4_BIT]           = is_ipv4;
    key[IPV6_BIT]           = is_ipv6;
    key[ARP_BIT]            = is_arp;
    key[FRAG_BIT]           = is_fragmented;
  end

endmodule

// File: rtl/flow_key_lookup_ctrl.sv
// Flow key lookup controller: captures a normalized key, issues one TCAM lookup,
// waits for the response or a timeout and hands the result downstream.
module flow_key_lookup_ctrl
  import net_dp_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  flow_key_lookup_ctrl_if.slave bus,
  output logic [15:0]           stat_lookups,
  output logic [15:0]           stat_misses,
  output logic [15:0]           stat_timeouts
);

  lookup_state_e    state;
  lookup_state_e    state_nxt;
  logic [KEY_W-1:0] packed_key;
  logic [KEY_W-1:0] key_q;
  logic [15:0]      timer;
  logic             timer_expired;
  logic             key_take;
  logic             req_fire;
  logic             rsp_take;
  logic             timeout_take;
  logic             hit_q;
  logic [7:0]       index_q;
  logic             timeout_q;

  flow_key_pack u_pack (
    .src_ip        (bus.key_src_ip),
    .dst_ip        (bus.key_dst_ip),
    .ip_proto      (bus.key_ip_proto),
    .src_port      (bus.key_src_port),
    .dst_port      (bus.key_dst_port),
    .vlan_id       (bus.key_vlan_id),
    .dscp          (bus.key_dscp),
    .is_ipv4       (bus.key_is_ipv4),
    .is_ipv6       (bus.key_is_ipv6),
    .is_arp        (bus.key_is_arp),
    .is_fragmented (bus.key_is_fragmented),
    .key           (packed_key)
  );

  assign timer_expired = (timer == 16'(TIMEOUT_CYC - 1));
  assign key_take      = (state == ST_IDLE) && bus.key_valid;
  assign req_fire      = (state == ST_REQ)  && bus.tcam_req_ready;
  // A response landing on the expiry cycle wins over the timeout.
  assign rsp_take      = (state == ST_WAIT) && bus.tcam_rsp_valid;
  assign timeout_take  = (state == ST_WAIT) && !bus.tcam_rsp_valid && timer_expired;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.key_valid)                         state_nxt = ST_REQ;
      ST_REQ:  if (bus.tcam_req_ready)                    state_nxt = ST_WAIT;
      ST_WAIT: if (bus.tcam_rsp_valid || timer_expired)   state_nxt = ST_OUT;
      ST_OUT:  if (bus.res_ready)                         state_nxt = ST_IDLE;
      default:                                            state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q         <= '0;
      timer         <= '0;
      hit_q         <= 1'b0;
      index_q       <= '0;
      timeout_q     <= 1'b0;
      stat_lookups  <= '0;
      stat_misses   <= '0;
      stat_timeouts <= '0;
    end else begin
      if (key_take) begin
        key_q <= packed_key;
      end
      if (req_fire) begin
        timer        <= '0;
        stat_lookups <= sat_inc16(stat_lookups);
      end else if ((state == ST_WAIT) && !bus.tcam_rsp_valid && !timer_expired) begin
        timer <= timer + 16'd1;
      end
      if (rsp_take) begin
        hit_q     <= bus.tcam_rsp_hit;
        index_q   <= bus.tcam_rsp_index;
        timeout_q <= 1'b0;
        if (!bus.tcam_rsp_hit) begin
          stat_misses <= sat_inc16(stat_misses);
        end
      end else if (timeout_take) begin
        hit_q         <= 1'b0;
        index_q       <= '0;
        timeout_q     <= 1'b1;
        stat_timeouts <= sat_inc16(stat_timeouts);
      end
    end
  end

  assign bus.key_ready      = (state == ST_IDLE);
  assign bus.tcam_req_valid = (state == ST_REQ);
  assign bus.tcam_key       = key_q;
  assign bus.res_valid      = (state == ST_OUT);
  assign bus.res_hit        = hit_q;
  assign bus.res_index      = index_q;
  assign bus.res_timeout    = timeout_q;

endmodule

// File: tb/tb_flow_key_lookup_ctrl.sv
// Scoreboard bench for flow_key_lookup_ctrl: directed lookups push expected keys
// and results; a negedge monitor pops and compares on each handshake.
module tb_flow_key_lookup_ctrl;
  import net_dp_pkg::*;

  localparam int TO_CYC = 4;

  typedef struct packed {
    logic       hit;
    logic [7:0] index;
    logic       timeout;
  } res_t;

  typedef struct packed {
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [7:0]  proto;
    logic [15:0] sport;
    logic [15:0] dport;
    logic [11:0] vlan;
    logic [5:0]  dscp;
    logic [3:0]  flags;
  } key_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] stat_lookups;
  logic [15:0] stat_misses;
  logic [15:0] stat_timeouts;

  int checks = 0;
  int failures = 0;
  int exp_lookups = 0;
  int exp_misses = 0;
  int exp_timeouts = 0;

  res_t       exp_res_q[$];
  logic [127:0] exp_key_q[$];

  flow_key_lookup_ctrl_if bus ();

  flow_key_lookup_ctrl #(.TIMEOUT_CYC(TO_CYC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .stat_lookups  (stat_lookups),
    .stat_misses   (stat_misses),
    .stat_timeouts (stat_timeouts)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic check_stats(input string tag);
    check_output({tag, "_stat_lookups"},  128'(stat_lookups),  128'(exp_lookups));
    check_output({tag, "_stat_misses"},   128'(stat_misses),   128'(exp_misses));
    check_output({tag, "_stat_timeouts"}, 128'(stat_timeouts), 128'(exp_timeouts));
  endtask

  function automatic key_t mk_key(input logic [31:0] s, input logic [31:0] d, input logic [7:0] p,
                                  input logic [15:0] sp, input logic [15:0] dp, input logic [11:0] v,
                                  input logic [5:0] ds, input logic [3:0] flags);
    key_t k;
    k.src_ip = s; k.dst_ip = d; k.proto = p; k.sport = sp; k.dport = dp;
    k.vlan = v; k.dscp = ds; k.flags = flags;
    return k;
  endfunction

  task automatic drive_key(input key_t k);
    bus.key_src_ip        = k.src_ip;
    bus.key_dst_ip        = k.dst_ip;
    bus.key_ip_proto      = k.proto;
    bus.key_src_port      = k.sport;
    bus.key_dst_port      = k.dport;
    bus.key_vlan_id       = k.vlan;
    bus.key_dscp          = k.dscp;
    bus.key_is_ipv4       = k.flags[3];
    bus.key_is_ipv6       = k.flags[2];
    bus.key_is_arp        = k.flags[1];
    bus.key_is_fragmented = k.flags[0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares the key on every TCAM request handshake and the result on every result handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.tcam_req_valid && bus.tcam_req_ready) begin
        if (exp_key_q.size() == 0) check_output("unexpected_tcam_req", 128'(1), 128'(0));
        else check_output("tcam_key", bus.tcam_key, exp_key_q.pop_front());
      end
      if (bus.res_valid && bus.res_ready) begin
        if (exp_res_q.size() == 0) check_output("unexpected_result", 128'(1), 128'(0));
        else check_output("result_hit_idx_to", 128'({bus.res_hit, bus.res_index, bus.res_timeout}),
                          128'(exp_res_q.pop_front()));
      end
    end
  end

  // rsp_delay < 0 means the TCAM never answers.
  task automatic apply_stimulus(input string tag, input key_t k, input logic [127:0] exp_key,
                                input int req_stall, input int rsp_delay, input logic rsp_hit,
                                input logic [7:0] rsp_idx, input int res_hold, output int wait_cyc);
    res_t exp;
    exp.hit     = (rsp_delay >= 0) ? rsp_hit : 1'b0;
    exp.index   = (rsp_delay >= 0) ? rsp_idx : 8'd0;
    exp.timeout = (rsp_delay < 0);
    exp_key_q.push_back(exp_key);
    exp_res_q.push_back(exp);

    drive_key(k);
    bus.key_valid      = 1'b1;
    bus.tcam_req_ready = (req_stall == 0);
    bus.res_ready      = (res_hold == 0);
    tick();
    bus.key_valid = 1'b0;
    check_output({tag, "_req_valid_after_accept"}, 128'(bus.tcam_req_valid), 128'(1));
    for (int i = 0; i < req_stall; i++) begin
      check_output({tag, "_req_stall_hold"}, 128'({bus.tcam_req_valid, stat_lookups}),
                   128'({1'b1, 16'(exp_lookups)}));
      tick();
    end
    bus.tcam_req_ready = 1'b1;
    tick();
    exp_lookups++;

    if (rsp_delay >= 0) begin
      repeat (rsp_delay) tick();
      bus.tcam_rsp_valid = 1'b1;
      bus.tcam_rsp_hit   = rsp_hit;
      bus.tcam_rsp_index = rsp_idx;
      tick();
      bus.tcam_rsp_valid = 1'b0;
      bus.tcam_rsp_hit   = 1'b0;
      bus.tcam_rsp_index = 8'd0;
      if (!rsp_hit) exp_misses++;
    end else begin
      exp_timeouts++;
    end

    wait_cyc = 0;
    while (!bus.res_valid && wait_cyc < 20) begin
      tick();
      wait_cyc++;
    end
    check_output({tag, "_res_valid_seen"}, 128'(bus.res_valid), 128'(1));

    if (res_hold > 0) begin
      bus.key_valid = 1'b1;
      for (int i = 0; i < res_hold; i++) begin
        tick();
        check_output({tag, "_backpressure_hold"},
                     128'({bus.key_ready, bus.res_valid, bus.tcam_req_valid, bus.res_hit, bus.res_index, bus.res_timeout}),
                     128'({1'b0, 1'b1, 1'b0, exp.hit, exp.index, exp.timeout}));
      end
      bus.key_valid = 1'b0;
      bus.res_ready = 1'b1;
    end
    tick();
    check_output({tag, "_back_to_idle"}, 128'({bus.key_ready, bus.res_valid}), 128'({1'b1, 1'b0}));
    check_stats(tag);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    key_t k_v4;
    bus.key_valid = 1'b0;
    drive_key('0);
    bus.tcam_req_ready = 1'b1;
    bus.tcam_rsp_valid = 1'b0;
    bus.tcam_rsp_hit   = 1'b0;
    bus.tcam_rsp_index = 8'd0;
    bus.res_ready      = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check_output("reset_ctrl", 128'({bus.key_ready, bus.tcam_req_valid, bus.res_valid}), 128'({1'b1, 1'b0, 1'b0}));
    check_output("reset_result", 128'({bus.res_hit, bus.res_index, bus.res_timeout}), 128'(0));
    check_output("reset_tcam_key", bus.tcam_key, 128'(0));
    check_stats("reset");
    rst_n = 1'b1;
    tick();

    // IPv4 TCP hit, minimum latency
    k_v4 = mk_key(32'h0A000001, 32'h0A000002, 8'h06, 16'd1234, 16'd80, 12'd5, 6'd46, 4'b1000);
    apply_stimulus("ipv4_hit", k_v4, 128'h0A000001_0A000002_0604D200_50005BA0, 0, 0, 1'b1, 8'h17, 0, n);
    check_output("ipv4_hit_latency", 128'(n), 128'(0));

    // ARP with junk L4 fields, TCAM request backpressured, miss
    apply_stimulus("arp_miss", mk_key(32'hC0A80001, 32'hC0A80002, 8'h06, 16'h1111, 16'h2222, 12'd0, 6'd0, 4'b0010),
                   128'hC0A80001_C0A80002_00000000_00000008, 3, 1, 1'b0, 8'h42, 0, n);

    // No response: timeout after TO_CYC wait cycles
    apply_stimulus("timeout", k_v4, 128'h0A000001_0A000002_0604D200_50005BA0, 0, -1, 1'b0, 8'h00, 0, n);
    check_output("timeout_wait_cycles", 128'(n), 128'(TO_CYC));

    // Response exactly on the expiry cycle counts as a response
    apply_stimulus("rsp_on_expiry", k_v4, 128'h0A000001_0A000002_0604D200_50005BA0, 0, TO_CYC - 1, 1'b1, 8'h3C, 0, n);

    // IPv6 fragment: ports forced to zero
    apply_stimulus("ipv6_frag", mk_key(32'h11111111, 32'h22222222, 8'h11, 16'hAAAA, 16'hBBBB, 12'hFFF, 6'h3F, 4'b0101),
                   128'h11111111_22222222_11000000_00FFFFD4, 0, 1, 1'b1, 8'h99, 0, n);

    // Unknown L3: addresses, proto and ports forced to zero
    apply_stimulus("non_l3", mk_key(32'hDEADBEEF, 32'hCAFEF00D, 8'h06, 16'd1, 16'd2, 12'h00A, 6'h01, 4'b0001),
                   128'h00000000_00000000_00000000_0000A044, 0, 2, 1'b0, 8'h00, 0, n);

    // Result backpressure for 10 cycles with a new key waiting
    apply_stimulus("res_backpressure", mk_key(32'h01020304, 32'h05060708, 8'h11, 16'h0035, 16'h1000, 12'd0, 6'd0, 4'b1000),
                   128'h01020304_05060708_11003510_00000020, 0, 0, 1'b1, 8'h5A, 10, n);

    // Reset while waiting on the TCAM, then a stray response
    exp_key_q.push_back(128'h0A000001_0A000002_0604D200_50005BA0);
    drive_key(k_v4);
    bus.key_valid = 1'b1;
    tick();
    bus.key_valid = 1'b0;
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    check_output("midreset_ctrl", 128'({bus.key_ready, bus.tcam_req_valid, bus.res_valid}), 128'({1'b1, 1'b0, 1'b0}));
    check_output("midreset_result", 128'({bus.res_hit, bus.res_index, bus.res_timeout}), 128'(0));
    check_output("midreset_tcam_key", bus.tcam_key, 128'(0));
    exp_lookups = 0; exp_misses = 0; exp_timeouts = 0;
    check_stats("midreset");
    tick();
    rst_n = 1'b1;
    bus.tcam_rsp_valid = 1'b1;
    bus.tcam_rsp_hit   = 1'b1;
    bus.tcam_rsp_index = 8'hEE;
    tick();
    bus.tcam_rsp_valid = 1'b0;
    bus.tcam_rsp_hit   = 1'b0;
    bus.tcam_rsp_index = 8'h00;
    for (int i = 0; i < 5; i++) begin
      check_output("stray_rsp_ignored",
                   128'({bus.key_ready, bus.tcam_req_valid, bus.res_valid, bus.res_hit, bus.res_index, bus.res_timeout}),
                   128'({1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0}));
      tick();
    end
    check_stats("post_reset");

    check_output("key_queue_drained", 128'(exp_key_q.size()), 128'(0));
    check_output("result_queue_drained", 128'(exp_res_q.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
